// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_if
// Brief    : Request/response handshakes plus the nbitalu drive/sample lines.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_carry;
    logic         rsp_ovf;
    logic         rsp_err;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         alu_ainv;
    logic         alu_binv;
    logic         alu_cin;
    logic [1:0]   alu_select;
    logic [N-1:0] alu_result;
    logic         alu_cout;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_cout,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf,
               rsp_err, alu_a, alu_b, alu_ainv, alu_binv, alu_cin, alu_select
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_cout,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_ovf,
               rsp_err, alu_a, alu_b, alu_ainv, alu_binv, alu_cin, alu_select
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Decodes requests onto an external nbitalu and returns result/flags;
//            shift-add MUL is built only when ALU_OP_SEQ_MUL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int N = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_op_sequencer_if.slave  bus
);
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_mul  = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_add = 3'b010;
    localparam logic [2:0] c_op_sub = 3'b011;
    localparam logic [2:0] c_op_slt = 3'b100;
    localparam logic [2:0] c_op_nor = 3'b101;
    localparam logic [2:0] c_op_mul = 3'b110;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [2:0]   r_op;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_result;
    logic         r_zero;
    logic         r_carry;
    logic         r_ovf;
    logic         r_err;

    logic [N-1:0] w_alu_a;
    logic [N-1:0] w_alu_b;
    logic         w_ainv;
    logic         w_binv;
    logic         w_cin;
    logic [1:0]   w_sel;
    logic         w_err;
    logic         w_req_mul;
    logic         w_mul_last;
    logic         w_accept;

    logic [N-1:0] w_res;
    logic         w_carry;
    logic         w_ovf;
    logic         w_ovf_add;
    logic         w_ovf_sub;

`ifdef ALU_OP_SEQ_MUL_EN
    localparam int         CW         = $clog2(N);
    localparam logic [CW-1:0] c_cnt_last = CW'(N - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic [N-1:0]  r_p;
    logic [N-1:0]  r_m;
    logic [N-1:0]  r_q;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  w_p_nxt;

    assign w_req_mul  = (bus.req_op == c_op_mul);
    assign w_mul_last = (r_cnt == c_cnt_last);
    assign w_p_nxt    = r_q[0] ? bus.alu_result : r_p;
`else
    assign w_req_mul  = 1'b0;
    assign w_mul_last = 1'b0;
`endif

    assign w_accept = (r_state == c_st_idle) && bus.req_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_alu_a     = '0;
        w_alu_b     = '0;
        w_ainv      = 1'b0;
        w_binv      = 1'b0;
        w_cin       = 1'b0;
        w_sel       = 2'b00;
        w_err       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (bus.req_valid) begin
                    w_state_nxt = w_req_mul ? c_st_mul : c_st_exec;
                end
            end
            c_st_exec: begin
                w_alu_a     = r_a;
                w_alu_b     = r_b;
                w_state_nxt = c_st_resp;
                case (r_op)
                    c_op_and: w_sel = 2'b00;
                    c_op_or:  w_sel = 2'b01;
                    c_op_add: w_sel = 2'b10;
                    c_op_sub, c_op_slt: begin
                        w_binv = 1'b1;
                        w_cin  = 1'b1;
                        w_sel  = 2'b10;
                    end
                    c_op_nor: begin
                        w_ainv = 1'b1;
                        w_binv = 1'b1;
                    end
                    default: begin
                        // Unsupported opcode: ALU sees idle controls and zero operands.
                        w_err   = 1'b1;
                        w_alu_a = '0;
                        w_alu_b = '0;
                    end
                endcase
            end
`ifdef ALU_OP_SEQ_MUL_EN
            c_st_mul: begin
                w_alu_a = r_p;
                w_alu_b = r_m;
                w_sel   = 2'b10;
                if (w_mul_last) begin
                    w_state_nxt = c_st_resp;
                end
            end
`endif
            c_st_resp: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Overflow is judged against the captured operands, not the inverted ALU inputs.
    assign w_ovf_add = (r_a[N-1] == r_b[N-1]) && (bus.alu_result[N-1] != r_a[N-1]);
    assign w_ovf_sub = (r_a[N-1] != r_b[N-1]) && (bus.alu_result[N-1] != r_a[N-1]);

    always_comb begin
        w_res   = bus.alu_result;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_op)
            c_op_add: begin
                w_carry = bus.alu_cout;
                w_ovf   = w_ovf_add;
            end
            c_op_sub: begin
                w_carry = bus.alu_cout;
                w_ovf   = w_ovf_sub;
            end
            c_op_slt: begin
                w_res   = {{(N-1){1'b0}}, bus.alu_result[N-1] ^ w_ovf_sub};
                w_carry = bus.alu_cout;
                w_ovf   = w_ovf_sub;
            end
            c_op_and, c_op_or, c_op_nor: w_res = bus.alu_result;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op <= bus.req_op;
                r_a  <= bus.req_a;
                r_b  <= bus.req_b;
            end
            if (r_state == c_st_exec) begin
                r_result <= w_err ? '0 : w_res;
                r_zero   <= w_err ? 1'b1 : (w_res == '0);
                r_carry  <= w_err ? 1'b0 : w_carry;
                r_ovf    <= w_err ? 1'b0 : w_ovf;
                r_err    <= w_err;
            end
`ifdef ALU_OP_SEQ_MUL_EN
            if ((r_state == c_st_mul) && w_mul_last) begin
                r_result <= w_p_nxt;
                r_zero   <= (w_p_nxt == '0);
                r_carry  <= 1'b0;
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
            end
`endif
        end
    end

`ifdef ALU_OP_SEQ_MUL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_m   <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_p   <= '0;
            r_m   <= bus.req_a;
            r_q   <= bus.req_b;
            r_cnt <= '0;
        end else if (r_state == c_st_mul) begin
            r_p   <= w_p_nxt;
            r_m   <= r_m << 1;
            r_q   <= r_q >> 1;
            r_cnt <= r_cnt + c_cnt_one;
        end
    end
`endif

    assign bus.req_ready  = (r_state == c_st_idle);
    assign bus.rsp_valid  = (r_state == c_st_resp);
    assign bus.rsp_result = r_result;
    assign bus.rsp_zero   = r_zero;
    assign bus.rsp_carry  = r_carry;
    assign bus.rsp_ovf    = r_ovf;
    assign bus.rsp_err    = r_err;
    assign bus.alu_a      = w_alu_a;
    assign bus.alu_b      = w_alu_b;
    assign bus.alu_ainv   = w_ainv;
    assign bus.alu_binv   = w_binv;
    assign bus.alu_cin    = w_cin;
    assign bus.alu_select = w_sel;
endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Self-checking bench with a stand-in nbitalu and an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
    localparam int N = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    alu_op_sequencer_if #(.N(N)) bus ();

    alu_op_sequencer #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the ripple-carry nbitalu the sequencer drives.
    always_comb begin
        logic [N-1:0] aa;
        logic [N-1:0] bb;
        logic [N:0]   s;
        aa = bus.alu_ainv ? ~bus.alu_a : bus.alu_a;
        bb = bus.alu_binv ? ~bus.alu_b : bus.alu_b;
        s  = {1'b0, aa} + {1'b0, bb} + {{N{1'b0}}, bus.alu_cin};
        case (bus.alu_select)
            2'b00:   bus.alu_result = aa & bb;
            2'b01:   bus.alu_result = aa | bb;
            default: bus.alu_result = s[N-1:0];
        endcase
        bus.alu_cout = s[N];
    end

`ifdef ALU_OP_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    // Reference: flags packed as {zero, carry, ovf, err}.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
        longint sa, sb, t;
        logic c, o, e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; c = 1'b0; o = 1'b0; e = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                t = sa + sb;
                r = a + b;
                c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd3, 3'd4: begin
                t = sa - sb;
                r = (op == 3'd3) ? (a - b) : ((sa < sb) ? 32'd1 : 32'd0);
                c = (a >= b);
                o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd5: r = ~(a | b);
            3'd6: if (MUL_ON) r = a * b; else e = 1'b1;
            default: e = 1'b1;
        endcase
        f = {(r == 32'd0), c, o, e};
    endfunction

    function automatic logic [4:0] exp_ctrl(input logic [2:0] op);
        case (op)
            3'd1:       return 5'b00001;
            3'd2:       return 5'b00010;
            3'd3, 3'd4: return 5'b01110;
            3'd5:       return 5'b11000;
            default:    return 5'b00000;
        endcase
    endfunction

    // One full transaction: returns latency, payload, and ALU drive seen in the first cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic [3:0] flg,
                          output logic [4:0] ctl, output logic [63:0] opnd);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = 1'b1;
        lat = 0; ctl = '0; opnd = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.req_valid = 1'b0;
                ctl  = {bus.alu_ainv, bus.alu_binv, bus.alu_cin, bus.alu_select};
                opnd = {bus.alu_a, bus.alu_b};
            end
        end while (!bus.rsp_valid && lat < 200);
        res = bus.rsp_result;
        flg = {bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf, bus.rsp_err};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
            $display("FAIL reset_hs: ready=%b valid=%b required 1/0", bus.req_ready, bus.rsp_valid);
        else n_pass++;
        n_checks++;
        if ({bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf, bus.rsp_err} !== 36'd0)
            $display("FAIL reset_payload: result=%h flags=%b%b%b%b required 0", bus.rsp_result,
                     bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf, bus.rsp_err);
        else n_pass++;
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_ainv, bus.alu_binv, bus.alu_cin, bus.alu_select} !== 69'd0)
            $display("FAIL reset_alu: a=%h b=%h ctl=%b%b%b%b required 0", bus.alu_a, bus.alu_b,
                     bus.alu_ainv, bus.alu_binv, bus.alu_cin, bus.alu_select);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [7] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd7, 3'd6};
        logic [31:0] as   [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd9, 32'h0001_0001};
        logic [31:0] bs   [7] = '{32'h1, 32'h1, 32'h1, 32'd3, 32'd0, 32'd4, 32'h0001_0001};
        logic [31:0] er   [7] = '{32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0,
                                  MUL_ON ? 32'h0002_0001 : 32'h0};
        logic [3:0]  ef   [7] = '{4'b1100, 4'b0110, 4'b0100, 4'b1100, 4'b0000, 4'b1001,
                                  MUL_ON ? 4'b0000 : 4'b1001};
        int          el   [7] = '{2, 2, 2, 2, 2, 2, MUL_ON ? 33 : 2};
        logic [4:0]  ec   [7] = '{5'b00010, 5'b01110, 5'b01110, 5'b01110, 5'b11000, 5'b00000,
                                  MUL_ON ? 5'b00010 : 5'b00000};
        int lat; logic [31:0] res; logic [3:0] flg; logic [4:0] ctl; logic [63:0] opnd;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, flg, ctl, opnd);
            n_checks++;
            if (lat !== el[i]) $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, el[i]);
            else n_pass++;
            n_checks++;
            if (res !== er[i]) $display("FAIL dir%0d_result: got %h required %h", i, res, er[i]);
            else n_pass++;
            n_checks++;
            if (flg !== ef[i]) $display("FAIL dir%0d_flags: got %b required %b (zcoe)", i, flg, ef[i]);
            else n_pass++;
            n_checks++;
            if (ctl !== ec[i]) $display("FAIL dir%0d_ctrl: got %b required %b", i, ctl, ec[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        int lat, elat; logic [31:0] res, a, b, er; logic [3:0] flg, ef; logic [4:0] ctl; logic [63:0] opnd;
        logic [2:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            model(op, a, b, er, ef);
            elat = (op == 3'd6 && MUL_ON) ? N + 1 : 2;
            run_op(op, a, b, lat, res, flg, ctl, opnd);
            n_checks++;
            if (lat !== elat) $display("FAIL rnd%0d_latency op=%0d: got %0d required %0d", i, op, lat, elat);
            else n_pass++;
            n_checks++;
            if ({res, flg} !== {er, ef})
                $display("FAIL rnd%0d_payload op=%0d a=%h b=%h: got %h/%b required %h/%b",
                         i, op, a, b, res, flg, er, ef);
            else n_pass++;
            if (!(op == 3'd6 && MUL_ON)) begin
                n_checks++;
                if ({ctl, opnd} !== {exp_ctrl(op), (ef[0] ? 64'd0 : {a, b})})
                    $display("FAIL rnd%0d_alu_drive op=%0d: ctl=%b opnd=%h required ctl=%b", i, op,
                             ctl, opnd, exp_ctrl(op));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a1, b1, a2, b2, er, hold; logic [3:0] ef;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        model(3'd2, a1, b1, er, ef);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = 3'd2; bus.req_a = a1; bus.req_b = b1;
        @(negedge clk);
        bus.req_op = 3'd1; bus.req_a = ~a1; bus.req_b = ~b1;
        @(negedge clk);
        hold = bus.rsp_result;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_result !== er)
                $display("FAIL bp_hold%0d: valid=%b ready=%b result=%h required 1/0/%h", i,
                         bus.rsp_valid, bus.req_ready, bus.rsp_result, er);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (bus.rsp_result !== hold) $display("FAIL bp_stable: got %h required %h", bus.rsp_result, hold);
        else n_pass++;
        // Next request is already pending when the consumer releases backpressure.
        bus.rsp_ready = 1'b1;
        bus.req_op = 3'd0; bus.req_a = a2; bus.req_b = b2;
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            $display("FAIL bp_release: valid=%b ready=%b required 0/1", bus.rsp_valid, bus.req_ready);
        else n_pass++;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b0) $display("FAIL b2b_accept: ready=%b required 0", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== (a2 & b2))
            $display("FAIL b2b_result: valid=%b result=%h required 1/%h", bus.rsp_valid,
                     bus.rsp_result, a2 & b2);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [31:0] res; logic [3:0] flg; logic [4:0] ctl; logic [63:0] opnd;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = MUL_ON ? 3'd6 : 3'd2;
        bus.req_a = 32'h1234_5678; bus.req_b = 32'h0000_0FFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
            $display("FAIL rst_mid_hs: valid=%b ready=%b required 0/1", bus.rsp_valid, bus.req_ready);
        else n_pass++;
        n_checks++;
        if ({bus.rsp_result, bus.alu_a, bus.alu_b, bus.alu_select} !== 98'd0)
            $display("FAIL rst_mid_clear: result=%h alu_a=%h alu_b=%h sel=%b required 0",
                     bus.rsp_result, bus.alu_a, bus.alu_b, bus.alu_select);
        else n_pass++;
        run_op(3'd2, 32'd2, 32'd3, lat, res, flg, ctl, opnd);
        n_checks++;
        if (res !== 32'd5 || flg !== 4'b0000 || lat !== 2)
            $display("FAIL rst_mid_add: result=%h flags=%b lat=%0d required 5/0000/2", res, flg, lat);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
